button_word_entry: RTL and testbench
====================================

// Module: button_word_entry
// PURPOSE
//   Parametrised push-button word-entry front end: debounces three raw buttons, shifts
//   logic0/logic1 presses into a WIDTH-bit word, mirrors fill level on LEDs, delivers the
//   completed word over a valid/ready handshake. Activity button: short press = backspace,
//   long hold = global activity_reset. Sits between board buttons and protocol/display logic.
// PARAMETERS
//   WIDTH           8            data bits per word (1..32)
//   DEBOUNCE_CYCLES 1_000_000    consecutive stable cycles before debounced level changes (>=1)
//   HOLD_CYCLES     150_000_000  activity held this many cycles -> activity_reset (> DEBOUNCE_CYCLES)
// PORTS
//   clk             in   1      system clock, all logic posedge
//   rst             in   1      asynchronous, active-high reset
//   logic0_button   in   1      raw button, 1 = pressed, asynchronous
//   logic1_button   in   1      raw button, 1 = pressed, asynchronous
//   activity_button in   1      raw button, 1 = pressed, asynchronous
//   word            out  WIDTH  assembled word, first-entered bit at MSB; valid while word_valid
//   word_valid      out  1      completed word available
//   word_ready      in   1      consumer accepts word when word_valid && word_ready
//   led             out  WIDTH  thermometer fill: led[i]=1 iff bit_count > i
//   bit_count       out  $clog2(WIDTH+1)  bits currently entered
//   activity_reset  out  1      1-cycle pulse on long hold
//   entry_err       out  1      1-cycle pulse: rejected press (both bits, entry while FULL)
//   parity_err      out  1      1-cycle pulse: parity check failed (see CONFIGURATION)
// BEHAVIOUR
//   Reset: all outputs 0, state ENTRY, shift reg/counters/timer 0, debounced levels 0.
//   Input path per button: 2-FF synchroniser -> counter; debounced level takes synced value
//     after DEBOUNCE_CYCLES consecutive differing samples; counter clears on any match.
//     press = 1-cycle pulse on debounced rise; release = 1-cycle pulse on debounced fall.
//   FSM ENTRY: press0 xor press1 -> shift in bit, bit_count+1 on the next edge.
//     press0 && press1 same cycle -> no shift, entry_err pulse.
//     bit_count reaches WIDTH -> state FULL, word_valid=1 in the same cycle count updates.
//   FSM FULL: word/led stable; bit presses ignored + entry_err. word_valid&&word_ready ->
//     ENTRY, bit_count=0, shift reg 0, word_valid=0 next cycle. word_valid never drops unaccepted.
//   Activity: press starts hold timer (saturating). release before HOLD_CYCLES = backspace:
//     ENTRY with bit_count>0 -> drop newest bit, count-1; bit_count==0 or FULL -> no effect.
//     Timer reaching HOLD_CYCLES while held -> activity_reset pulse exactly once per hold,
//     clears shift reg, bit_count, word_valid, state ENTRY; subsequent release does nothing.
//   Long-hold clear overrides simultaneous bit press or handshake in that cycle.
//   rst mid-operation: immediate async clear; no partial word or pulse survives.
// CONFIGURATION
//   BUTTON_WORD_ENTRY_PARITY_EN defined: word completes after WIDTH+1 entries; last entry is
//     even-parity bit over the WIDTH data bits (not stored in word). Match -> FULL as above;
//     mismatch -> discard, back to ENTRY count 0, parity_err pulse. led/bit_count saturate at WIDTH.
//   Undefined: WIDTH entries complete the word; parity_err tied 0.
// STRUCTURE
//   Package button_entry_pkg: state enum {ENTRY, FULL}, clog2-based width constants.
//   Sub-module btn_debounce_edge (sync + debounce + press/release pulses), instantiated x3.
//   Top holds FSM, shift register, hold timer, LED decode.
// TESTING (bench WIDTH=4, DEBOUNCE_CYCLES=3, HOLD_CYCLES=20)
//   Press 1,0,1,1 cleanly, word_ready=0 -> word=4'b1011, word_valid held, led=4'b1111, bit_count=4.
//   10-cycle glitch (1-cycle pulses) on logic1_button -> no bit entered, bit_count stays 0.
//   Enter 1,1, short activity press (5 cycles) -> bit_count=1, led=4'b0001; then 0,0,1 -> word=4'b1001.
//   Hold activity 30 cycles with 3 bits entered -> one activity_reset pulse, bit_count=0, led=0.
//   In FULL press logic0 -> entry_err pulse, word unchanged; assert word_ready -> word_valid=0 next cycle.
//   Press both bits same cycle -> entry_err, no shift; PARITY_EN build, enter 1,0,1,1,0 -> parity_err, count 0.

Source files
------------

// File: rtl/button_entry_pkg.sv
// Shared types and width helpers for the push-button word-entry front end.
// Pure declarations: no logic, no latency, no flow control.
package button_entry_pkg;

    typedef enum logic {
        ENTRY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Bits needed to hold any value 0..n inclusive (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_edge.sv
// Raw button -> 2-FF sync -> stability counter -> debounced level with press/release pulses.
// Pulses appear DEBOUNCE_CYCLES+2 edges after a clean raw change; no backpressure.
module btn_debounce_edge
    import button_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o,
    output logic release_o
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        // Any sample agreeing with the current level restarts the stability window.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
                rel_d   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = rel_q;

endmodule

// File: rtl/button_word_entry.sv
// Debounced three-button word entry: shift register + FSM, LED fill, valid/ready word out.
// Optional BUTTON_WORD_ENTRY_PARITY_EN adds a trailing even-parity entry; word_valid holds until accepted.
module button_word_entry
    import button_entry_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 150_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       logic0_button,
    input  logic                       logic1_button,
    input  logic                       activity_button,
    output logic [WIDTH-1:0]           word,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [WIDTH-1:0]           led,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       activity_reset,
    output logic                       entry_err,
    output logic                       parity_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int TW    = cnt_w(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD_CYCLES - 1);

    logic p0, p1, pa, r0, r1, ra;
    logic unused_releases;

    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
        .clk(clk), .rst(rst), .btn_i(logic0_button), .press_o(p0), .release_o(r0));
    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk(clk), .rst(rst), .btn_i(logic1_button), .press_o(p1), .release_o(r1));
    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dba (
        .clk(clk), .rst(rst), .btn_i(activity_button), .press_o(pa), .release_o(ra));

    assign unused_releases = r0 ^ r1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             armed_q, armed_d;
    logic             ee_q, ee_d;
    logic             pe_q, pe_d;
    logic             ar_q, ar_d;
    logic             backspace, fire;
    logic [WIDTH-1:0] shifted;

    assign shifted = (shreg_q << 1) | WIDTH'(p1);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        timer_d   = timer_q;
        armed_d   = armed_q;
        ee_d      = 1'b0;
        pe_d      = 1'b0;
        ar_d      = 1'b0;
        backspace = 1'b0;
        fire      = 1'b0;

        // Hold timer: armed on press, disarmed by release or by firing, so one pulse per hold.
        if (pa) begin
            armed_d = 1'b1;
            timer_d = '0;
        end else if (armed_q) begin
            if (ra) begin
                armed_d   = 1'b0;
                backspace = 1'b1;
            end else if (timer_q == HOLD_LAST) begin
                armed_d = 1'b0;
                fire    = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        if (fire) begin
            ar_d    = 1'b1;
            state_d = ENTRY;
            shreg_d = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (p0 && p1) begin
                        ee_d = 1'b1;
                    end else if (p0 || p1) begin
`ifdef BUTTON_WORD_ENTRY_PARITY_EN
                        // With all data bits in, the next entry is the even-parity bit.
                        if (cnt_q == CNT_FULL) begin
                            if (p1 == (^shreg_q)) begin
                                state_d = FULL;
                                valid_d = 1'b1;
                            end else begin
                                shreg_d = '0;
                                cnt_d   = '0;
                                pe_d    = 1'b1;
                            end
                        end else begin
                            shreg_d = shifted;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
`else
                        shreg_d = shifted;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_FULL - CNT_W'(1)) begin
                            state_d = FULL;
                            valid_d = 1'b1;
                        end
`endif
                    end else if (backspace && (cnt_q != '0)) begin
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                FULL: begin
                    if (p0 || p1) begin
                        ee_d = 1'b1;
                    end
                    if (valid_q && word_ready) begin
                        state_d = ENTRY;
                        shreg_d = '0;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = ENTRY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENTRY;
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            timer_q <= '0;
            armed_q <= 1'b0;
            ee_q    <= 1'b0;
            pe_q    <= 1'b0;
            ar_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            timer_q <= timer_d;
            armed_q <= armed_d;
            ee_q    <= ee_d;
            pe_q    <= pe_d;
            ar_q    <= ar_d;
        end
    end

    always_comb begin
        led = '0;
        for (int i = 0; i < WIDTH; i++) begin
            led[i] = (cnt_q > CNT_W'(i));
        end
    end

    assign word           = shreg_q;
    assign word_valid     = valid_q;
    assign bit_count      = cnt_q;
    assign activity_reset = ar_q;
    assign entry_err      = ee_q;
    assign parity_err     = pe_q;

endmodule

// File: tb/tb_button_word_entry.sv
// Directed bench for button_word_entry at WIDTH=4, DEBOUNCE_CYCLES=3, HOLD_CYCLES=20.
module tb_button_word_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b0 = 1'b0, b1 = 1'b0, ba = 1'b0;
    logic       word_ready = 1'b0;
    logic [3:0] word, led;
    logic [2:0] bit_count;
    logic       word_valid, activity_reset, entry_err, parity_err;

    int total = 0, bad = 0;
    int n_ee = 0, n_pe = 0, n_ar = 0;
    int e0, a0, q0;

    button_word_entry #(.WIDTH(4), .DEBOUNCE_CYCLES(3), .HOLD_CYCLES(20)) dut (
        .clk(clk), .rst(rst),
        .logic0_button(b0), .logic1_button(b1), .activity_button(ba),
        .word(word), .word_valid(word_valid), .word_ready(word_ready),
        .led(led), .bit_count(bit_count),
        .activity_reset(activity_reset), .entry_err(entry_err), .parity_err(parity_err));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (entry_err)      n_ee++;
        if (parity_err)     n_pe++;
        if (activity_reset) n_ar++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_bit(input logic v);
        if (v) b1 = 1'b1; else b0 = 1'b1;
        cyc(8);
        b0 = 1'b0;
        b1 = 1'b0;
        cyc(8);
    endtask

    task automatic press_act(input int n);
        ba = 1'b1;
        cyc(n);
        ba = 1'b0;
        cyc(8);
    endtask

    task automatic accept();
        word_ready = 1'b1;
        cyc(1);
        word_ready = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_valid", word_valid, 0);
        chk("rst_count", bit_count, 0);
        chk("rst_led", led, 0);
        chk("rst_word", word, 0);
        chk("rst_pulses", {activity_reset, entry_err, parity_err}, 0);
        rst = 1'b0;
        cyc(2);

        press_bit(1); press_bit(0); press_bit(1); press_bit(1);
`ifdef BUTTON_WORD_ENTRY_PARITY_EN
        press_bit(1);
`endif
        chk("w1011_word", word, 4'b1011);
        chk("w1011_valid", word_valid, 1);
        chk("w1011_led", led, 4'b1111);
        chk("w1011_count", bit_count, 4);
        cyc(20);
        chk("w1011_held", word_valid, 1);

        e0 = n_ee;
        press_bit(0);
        chk("full_press_err", n_ee, e0 + 1);
        chk("full_press_word", word, 4'b1011);
        chk("full_press_count", bit_count, 4);
        chk("full_press_valid", word_valid, 1);

        accept();
        chk("accept_valid", word_valid, 0);
        chk("accept_count", bit_count, 0);
        chk("accept_word", word, 0);

        repeat (5) begin
            b1 = 1'b1; cyc(1);
            b1 = 1'b0; cyc(1);
        end
        cyc(10);
        chk("glitch_count", bit_count, 0);
        chk("glitch_led", led, 0);

        press_bit(1); press_bit(1);
        chk("pre_bs_count", bit_count, 2);
        press_act(5);
        chk("bs_count", bit_count, 1);
        chk("bs_led", led, 4'b0001);
        press_bit(0); press_bit(0); press_bit(1);
`ifdef BUTTON_WORD_ENTRY_PARITY_EN
        press_bit(0);
`endif
        chk("w1001_word", word, 4'b1001);
        chk("w1001_valid", word_valid, 1);
        accept();

        press_bit(1); press_bit(0); press_bit(1);
        chk("pre_hold_count", bit_count, 3);
        a0 = n_ar;
        press_act(30);
        chk("hold_pulses", n_ar, a0 + 1);
        chk("hold_count", bit_count, 0);
        chk("hold_led", led, 0);
        chk("hold_valid", word_valid, 0);

        press_bit(1);
        e0 = n_ee;
        b0 = 1'b1; b1 = 1'b1;
        cyc(8);
        b0 = 1'b0; b1 = 1'b0;
        cyc(8);
        chk("both_err", n_ee, e0 + 1);
        chk("both_count", bit_count, 1);
        chk("both_word", word, 4'b0001);
        press_act(5);
        chk("bs_to_zero", bit_count, 0);
        press_act(5);
        chk("bs_at_zero", bit_count, 0);

`ifdef BUTTON_WORD_ENTRY_PARITY_EN
        q0 = n_pe;
        press_bit(1); press_bit(0); press_bit(1); press_bit(1);
        chk("par_sat_count", bit_count, 4);
        press_bit(0);
        chk("par_err", n_pe, q0 + 1);
        chk("par_count", bit_count, 0);
        chk("par_valid", word_valid, 0);
`else
        chk("no_parity_pulses", n_pe, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
